// File: rtl/lt24_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lt24_pkg
//  Description : Shared opcodes, init-list length, FSM state encoding and
//                small helpers for the LT24 LCD window writer.
//  Revision    : 1.0 - initial release
// ============================================================================
package lt24_pkg;

    // ILI9341 window / memory-write opcodes
    localparam logic [15:0] c_CMD_CASET = 16'h002A;
    localparam logic [15:0] c_CMD_PASET = 16'h002B;
    localparam logic [15:0] c_CMD_RAMWR = 16'h002C;

    // Number of words in the power-up command list
    localparam int INIT_LEN = 6;

    // Word index shared by the init list and the window-setup sequences
    localparam int SEQ_IDX_W = 3;

    // Words per address-window command: opcode plus four coordinate bytes
    localparam int WIN_WORDS = 5;

    typedef enum logic [3:0] {
        ST_RST_LOW  = 4'd0,
        ST_RST_WAIT = 4'd1,
        ST_INIT     = 4'd2,
        ST_IDLE     = 4'd3,
        ST_CASET    = 4'd4,
        ST_PASET    = 4'd5,
        ST_RAMWR    = 4'd6,
        ST_PIXELS   = 4'd7,
        ST_DONE     = 4'd8
    } lt24_state_e;

    // Data payload for word 1..4 of a CASET/PASET sequence (high byte first)
    function automatic logic [15:0] coord_word(input logic [15:0]          lo,
                                               input logic [15:0]          hi,
                                               input logic [SEQ_IDX_W-1:0] idx);
        logic [15:0] word;
        case (idx)
            3'd1:    word = {8'h00, lo[15:8]};
            3'd2:    word = {8'h00, lo[7:0]};
            3'd3:    word = {8'h00, hi[15:8]};
            3'd4:    word = {8'h00, hi[7:0]};
            default: word = 16'h0000;
        endcase
        return word;
    endfunction

    // Pixel count of an inclusive window; a full 240x320 panel fits in 17 bits
    function automatic logic [16:0] window_pixels(input logic [15:0] x0,
                                                  input logic [15:0] x1,
                                                  input logic [15:0] y0,
                                                  input logic [15:0] y1);
        return 17'((32'(x1) - 32'(x0) + 32'd1) * (32'(y1) - 32'(y0) + 32'd1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/lt24_init_rom.sv
`default_nettype none
// ============================================================================
//  Module      : lt24_init_rom
//  Description : Combinational power-up command list for the LT24 panel.
//                Output word is {dcx, data[15:0]}; dcx=0 marks a command.
//  Revision    : 1.0 - initial release
// ============================================================================
module lt24_init_rom
    import lt24_pkg::*;
(
    input  logic [SEQ_IDX_W-1:0] i_idx,
    output logic [16:0]          o_word
);

    // Sleep out, 16-bit pixel format, memory access control, display on
    always_comb begin
        case (i_idx)
            3'd0:    o_word = {1'b0, 16'h0011};
            3'd1:    o_word = {1'b0, 16'h003A};
            3'd2:    o_word = {1'b1, 16'h0055};
            3'd3:    o_word = {1'b0, 16'h0036};
            3'd4:    o_word = {1'b1, 16'h0048};
            3'd5:    o_word = {1'b0, 16'h0029};
            default: o_word = {1'b0, 16'h0000};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lt24_lcd_window_writer.sv
`default_nettype none
// ============================================================================
//  Module      : lt24_lcd_window_writer
//  Description : Brings up an LT24 panel (reset pulse, wait, init list) and
//                then writes rectangular windows over the 8080 bus, either
//                filled with a constant colour or from a valid/ready stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module lt24_lcd_window_writer
    import lt24_pkg::*;
#(
    parameter  int H_RES        = 240,
    parameter  int V_RES        = 320,
    parameter  int WR_LOW_CYC   = 1,
    parameter  int WR_HIGH_CYC  = 1,
    parameter  int RST_LOW_CYC  = 1000,
    parameter  int RST_WAIT_CYC = 120000,
    localparam int XW           = $clog2(H_RES),
    localparam int YW           = $clog2(V_RES)
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [XW-1:0] win_x0,
    input  logic [XW-1:0] win_x1,
    input  logic [YW-1:0] win_y0,
    input  logic [YW-1:0] win_y1,
    input  logic          fill_mode,
    input  logic [15:0]   fill_rgb,
    input  logic          start,
    input  logic [15:0]   pix_data,
    input  logic          pix_valid,
    output logic          pix_ready,
    output logic          initialized,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          tft_rst,
    output logic          tft_csx,
    output logic          tft_dcx,
    output logic          tft_wrx,
    output logic          tft_rdx,
    output logic [15:0]   tft_data
);

    localparam int c_DLY_MAX = (RST_WAIT_CYC > RST_LOW_CYC) ? RST_WAIT_CYC : RST_LOW_CYC;
    localparam int c_DLY_W   = $clog2(c_DLY_MAX + 1);
    localparam int c_WR_MAX  = (WR_HIGH_CYC > WR_LOW_CYC) ? WR_HIGH_CYC : WR_LOW_CYC;
    localparam int c_WR_W    = $clog2(c_WR_MAX + 1);

    localparam logic [c_DLY_W-1:0]   c_LOW_LAST   = c_DLY_W'(RST_LOW_CYC - 1);
    localparam logic [c_DLY_W-1:0]   c_WAIT_LAST  = c_DLY_W'(RST_WAIT_CYC - 1);
    localparam logic [c_WR_W-1:0]    c_WR_LOW_LD  = c_WR_W'(WR_LOW_CYC - 1);
    localparam logic [c_WR_W-1:0]    c_WR_HIGH_LD = c_WR_W'(WR_HIGH_CYC - 1);
    localparam logic [31:0]          c_H_RES      = 32'(H_RES);
    localparam logic [31:0]          c_V_RES      = 32'(V_RES);
    localparam logic [SEQ_IDX_W-1:0] c_INIT_END   = SEQ_IDX_W'(INIT_LEN);
    localparam logic [SEQ_IDX_W-1:0] c_WIN_END    = SEQ_IDX_W'(WIN_WORDS);
    localparam logic [SEQ_IDX_W-1:0] c_RAMWR_END  = SEQ_IDX_W'(1);

    lt24_state_e r_state;
    lt24_state_e w_state_next;

    logic [c_DLY_W-1:0]   r_dly;
    logic [SEQ_IDX_W-1:0] r_idx;
    logic [16:0]          r_pix_cnt;
    logic [15:0]          r_x0, r_x1, r_y0, r_y1;
    logic                 r_fill;
    logic [15:0]          r_rgb;

    // Bus-word engine: r_bus_busy covers both the low and the high phase
    logic                 r_bus_busy;
    logic                 r_wr_low;
    logic [c_WR_W-1:0]    r_wr_cnt;

    logic                 r_initialized, r_busy, r_done, r_err;
    logic                 r_tft_rst, r_tft_csx, r_tft_dcx, r_tft_wrx;
    logic [15:0]          r_tft_data;

    logic                 w_launch;
    logic [16:0]          w_launch_word;
    logic                 w_dly_clr, w_dly_inc;
    logic                 w_idx_clr, w_idx_inc;
    logic                 w_cnt_dec;
    logic                 w_accept, w_reject;
    logic                 w_init_done_set, w_done_set;
    logic                 w_pix_ready;
    logic                 w_win_bad;
    logic [16:0]          w_rom_word;
    logic [16:0]          w_caset_word, w_paset_word;

    lt24_init_rom u_init_rom (
        .i_idx  (r_idx),
        .o_word (w_rom_word)
    );

    assign w_win_bad = (win_x1 < win_x0) || (win_y1 < win_y0) ||
                       (32'(win_x1) >= c_H_RES) || (32'(win_y1) >= c_V_RES);

    assign w_caset_word = (r_idx == '0) ? {1'b0, c_CMD_CASET}
                                        : {1'b1, coord_word(r_x0, r_x1, r_idx)};
    assign w_paset_word = (r_idx == '0) ? {1'b0, c_CMD_PASET}
                                        : {1'b1, coord_word(r_y0, r_y1, r_idx)};

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RST_LOW;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-cycle control strobes; nothing advances while
    // en is low, and a new bus word is only launched once the engine is idle
    always_comb begin
        w_state_next    = r_state;
        w_launch        = 1'b0;
        w_launch_word   = 17'd0;
        w_dly_clr       = 1'b0;
        w_dly_inc       = 1'b0;
        w_idx_clr       = 1'b0;
        w_idx_inc       = 1'b0;
        w_cnt_dec       = 1'b0;
        w_accept        = 1'b0;
        w_reject        = 1'b0;
        w_init_done_set = 1'b0;
        w_done_set      = 1'b0;
        w_pix_ready     = 1'b0;
        case (r_state)
            ST_RST_LOW: begin
                if (en) begin
                    if (r_dly == c_LOW_LAST) begin
                        w_state_next = ST_RST_WAIT;
                        w_dly_clr    = 1'b1;
                    end else begin
                        w_dly_inc = 1'b1;
                    end
                end
            end
            ST_RST_WAIT: begin
                if (en) begin
                    if (r_dly == c_WAIT_LAST) begin
                        w_state_next = ST_INIT;
                        w_dly_clr    = 1'b1;
                    end else begin
                        w_dly_inc = 1'b1;
                    end
                end
            end
            ST_INIT: begin
                if (en && !r_bus_busy) begin
                    if (r_idx == c_INIT_END) begin
                        w_state_next    = ST_IDLE;
                        w_idx_clr       = 1'b1;
                        w_init_done_set = 1'b1;
                    end else begin
                        w_launch      = 1'b1;
                        w_launch_word = w_rom_word;
                        w_idx_inc     = 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (en && start && r_initialized) begin
                    if (w_win_bad) begin
                        w_reject = 1'b1;
                    end else begin
                        w_accept     = 1'b1;
                        w_state_next = ST_CASET;
                    end
                end
            end
            ST_CASET: begin
                if (en && !r_bus_busy) begin
                    if (r_idx == c_WIN_END) begin
                        w_state_next = ST_PASET;
                        w_idx_clr    = 1'b1;
                    end else begin
                        w_launch      = 1'b1;
                        w_launch_word = w_caset_word;
                        w_idx_inc     = 1'b1;
                    end
                end
            end
            ST_PASET: begin
                if (en && !r_bus_busy) begin
                    if (r_idx == c_WIN_END) begin
                        w_state_next = ST_RAMWR;
                        w_idx_clr    = 1'b1;
                    end else begin
                        w_launch      = 1'b1;
                        w_launch_word = w_paset_word;
                        w_idx_inc     = 1'b1;
                    end
                end
            end
            ST_RAMWR: begin
                if (en && !r_bus_busy) begin
                    if (r_idx == c_RAMWR_END) begin
                        w_state_next = ST_PIXELS;
                        w_idx_clr    = 1'b1;
                    end else begin
                        w_launch      = 1'b1;
                        w_launch_word = {1'b0, c_CMD_RAMWR};
                        w_idx_inc     = 1'b1;
                    end
                end
            end
            ST_PIXELS: begin
                if (en && !r_bus_busy) begin
                    if (r_pix_cnt == 17'd0) begin
                        w_state_next = ST_DONE;
                    end else if (r_fill) begin
                        w_launch      = 1'b1;
                        w_launch_word = {1'b1, r_rgb};
                        w_cnt_dec     = 1'b1;
                    end else begin
                        w_pix_ready = 1'b1;
                        if (pix_valid) begin
                            w_launch      = 1'b1;
                            w_launch_word = {1'b1, pix_data};
                            w_cnt_dec     = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (en) begin
                    w_state_next = ST_IDLE;
                    w_done_set   = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_RST_LOW;
            end
        endcase
    end

    // Counters, latched request, status flags and the registered 8080 bus
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dly         <= '0;
            r_idx         <= '0;
            r_pix_cnt     <= 17'd0;
            r_x0          <= 16'd0;
            r_x1          <= 16'd0;
            r_y0          <= 16'd0;
            r_y1          <= 16'd0;
            r_fill        <= 1'b0;
            r_rgb         <= 16'd0;
            r_bus_busy    <= 1'b0;
            r_wr_low      <= 1'b0;
            r_wr_cnt      <= '0;
            r_initialized <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_tft_rst     <= 1'b0;
            r_tft_csx     <= 1'b1;
            r_tft_dcx     <= 1'b1;
            r_tft_wrx     <= 1'b1;
            r_tft_data    <= 16'd0;
        end else begin
            r_done    <= w_done_set;
            r_err     <= w_reject;
            r_tft_rst <= (w_state_next != ST_RST_LOW);

            if (w_dly_clr) begin
                r_dly <= '0;
            end else if (w_dly_inc) begin
                r_dly <= r_dly + 1'b1;
            end

            if (w_idx_clr) begin
                r_idx <= '0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + 1'b1;
            end

            if (w_accept) begin
                r_x0      <= 16'(win_x0);
                r_x1      <= 16'(win_x1);
                r_y0      <= 16'(win_y0);
                r_y1      <= 16'(win_y1);
                r_fill    <= fill_mode;
                r_rgb     <= fill_rgb;
                r_pix_cnt <= window_pixels(16'(win_x0), 16'(win_x1),
                                           16'(win_y0), 16'(win_y1));
                r_busy    <= 1'b1;
            end else if (w_cnt_dec) begin
                r_pix_cnt <= r_pix_cnt - 1'b1;
            end

            if (w_done_set) begin
                r_busy <= 1'b0;
            end

            if (w_init_done_set) begin
                r_initialized <= 1'b1;
            end

            // The engine runs to the end of its word regardless of en, so a
            // pause never leaves tft_wrx parked low
            if (w_launch) begin
                r_bus_busy <= 1'b1;
                r_wr_low   <= 1'b1;
                r_wr_cnt   <= c_WR_LOW_LD;
                r_tft_csx  <= 1'b0;
                r_tft_dcx  <= w_launch_word[16];
                r_tft_data <= w_launch_word[15:0];
                r_tft_wrx  <= 1'b0;
            end else if (r_bus_busy) begin
                if (r_wr_cnt != '0) begin
                    r_wr_cnt <= r_wr_cnt - 1'b1;
                end else if (r_wr_low) begin
                    r_tft_wrx <= 1'b1;
                    r_wr_low  <= 1'b0;
                    r_wr_cnt  <= c_WR_HIGH_LD;
                end else begin
                    r_bus_busy <= 1'b0;
                end
            end else if (w_done_set || w_init_done_set) begin
                r_tft_csx <= 1'b1;
            end
        end
    end

    assign pix_ready   = w_pix_ready;
    assign initialized = r_initialized;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign tft_rst     = r_tft_rst;
    assign tft_csx     = r_tft_csx;
    assign tft_dcx     = r_tft_dcx;
    assign tft_wrx     = r_tft_wrx;
    assign tft_rdx     = 1'b1;
    assign tft_data    = r_tft_data;

endmodule
`default_nettype wire
